// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN loader path: packet types, image size and
// per-layer kernel address limits.
package bnn_pkg;

  typedef enum logic [1:0] {
    PKT_IMG   = 2'd0,
    PKT_CONV1 = 2'd1,
    PKT_CONV2 = 2'd2,
    PKT_FC    = 2'd3
  } pkt_type_e;

  localparam int IMG_BYTES   = 98;
  localparam int KBITS_BYTES = 4;
  localparam int CONV1_LIMIT = 90;
  localparam int CONV2_LIMIT = 1080;
  localparam int FC_LIMIT    = 10;

  // Exclusive upper bound on the kernel index for a layer; 12 bits so 1080 fits.
  function automatic logic [11:0] addr_limit(input pkt_type_e t);
    case (t)
      PKT_CONV1: addr_limit = 12'(CONV1_LIMIT);
      PKT_CONV2: addr_limit = 12'(CONV2_LIMIT);
      PKT_FC:    addr_limit = 12'(FC_LIMIT);
      default:   addr_limit = 12'd0;
    endcase
  endfunction

endpackage

// File: rtl/serial_loader.sv
// Byte-stream packet loader: assembles 28x28 binary images and unpacks 5x5
// binary kernels with offset, address and layer for the BNN weight stores.
module serial_loader
  import bnn_pkg::*;
#(
  parameter int bW        = 8,
  parameter int IMG_BYTES = bnn_pkg::IMG_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [783:0]  image_out,
  output logic          image_out_valid,
  input  logic          image_out_ready,
  output logic          kernel_out_valid,
  output logic [24:0]   kernel_bits,
  output logic [bW-1:0] kernel_offset,
  output logic [10:0]   kernel_addr,
  output logic [1:0]    kernel_layer,
  output logic          err_addr
);

  typedef enum logic [2:0] {
    IDLE,
    IMG,
    K_AH,
    K_AL,
    K_OFF,
    K_BITS,
    IMG_HOLD,
    K_EMIT
  } state_e;

  state_e      state;
  pkt_type_e   layer_q;
  logic [6:0]  cnt;
  logic [2:0]  addr_hi;
  logic [7:0]  addr_lo;
  logic [7:0]  off_q;
  logic [23:0] kb_sr;
  logic [783:0] img_sr;
  logic [7:0]  din_rev;
  logic        xfer;
  logic        addr_ok;

  // Stall only while an assembled result is being presented.
  assign din_ready = !rst && (state != IMG_HOLD) && (state != K_EMIT);
  assign xfer      = din_valid && din_ready;
  assign din_rev   = {<<{din}};
  assign addr_ok   = {1'b0, addr_hi, addr_lo} < addr_limit(layer_q);

  // Partial images live only in img_sr; the port shows nothing until the hold.
  assign image_out = image_out_valid ? img_sr : '0;

  // NOTE: img_sr has no reset -- every image packet shifts all 784 bits
  // through before IMG_HOLD, and image_out is gated until then.
  always_ff @(posedge clk) begin
    if (state == IMG && xfer) begin
      img_sr <= {din_rev, img_sr[783:8]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      layer_q          <= PKT_IMG;
      cnt              <= '0;
      addr_hi          <= '0;
      addr_lo          <= '0;
      off_q            <= '0;
      kb_sr            <= '0;
      image_out_valid  <= 1'b0;
      kernel_out_valid <= 1'b0;
      kernel_bits      <= '0;
      kernel_offset    <= '0;
      kernel_addr      <= '0;
      kernel_layer     <= '0;
      err_addr         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          layer_q <= pkt_type_e'(din[7:6]);
          cnt     <= '0;
          state   <= (din[7:6] == 2'd0) ? IMG : K_AH;
        end
        IMG: if (xfer) begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'(IMG_BYTES - 1)) begin
            image_out_valid <= 1'b1;
            state           <= IMG_HOLD;
          end
        end
        IMG_HOLD: if (image_out_ready) begin
          image_out_valid <= 1'b0;
          state           <= IDLE;
        end
        K_AH: if (xfer) begin
          addr_hi <= din[2:0];
          state   <= K_AL;
        end
        K_AL: if (xfer) begin
          addr_lo <= din;
          state   <= K_OFF;
        end
        K_OFF: if (xfer) begin
          off_q <= din;
          cnt   <= '0;
          state <= K_BITS;
        end
        K_BITS: if (xfer) begin
          kb_sr <= {kb_sr[15:0], din};
          cnt   <= cnt + 7'd1;
          if (cnt == 7'(KBITS_BYTES - 1)) begin
            // Bad addresses are swallowed whole; outputs keep the last good kernel.
            if (addr_ok) begin
              kernel_bits      <= {kb_sr, din[7]};
              kernel_offset    <= bW'(off_q);
              kernel_addr      <= {addr_hi, addr_lo};
              kernel_layer     <= 2'(layer_q);
              kernel_out_valid <= 1'b1;
              state            <= K_EMIT;
            end else begin
              err_addr <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        K_EMIT: begin
          kernel_out_valid <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Scoreboard bench for serial_loader: image hold, kernel unpacking, range
// errors, input gaps, mid-packet reset and back-to-back packets.
module tb_serial_loader;
  import bnn_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [783:0]  image_out;
  logic          image_out_valid;
  logic          image_out_ready = 1'b1;
  logic          kernel_out_valid;
  logic [24:0]   kernel_bits;
  logic [7:0]    kernel_offset;
  logic [10:0]   kernel_addr;
  logic [1:0]    kernel_layer;
  logic          err_addr;

  typedef struct {
    bit           is_img;
    logic [783:0] img;
    logic [1:0]   layer;
    logic [10:0]  addr;
    logic [7:0]   off;
    logic [24:0]  bits;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_loader #(.bW(8), .IMG_BYTES(98)) dut (
    .clk              (clk),
    .rst              (rst),
    .din              (din),
    .din_valid        (din_valid),
    .din_ready        (din_ready),
    .image_out        (image_out),
    .image_out_valid  (image_out_valid),
    .image_out_ready  (image_out_ready),
    .kernel_out_valid (kernel_out_valid),
    .kernel_bits      (kernel_bits),
    .kernel_offset    (kernel_offset),
    .kernel_addr      (kernel_addr),
    .kernel_layer     (kernel_layer),
    .err_addr         (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [783:0] act, input logic [783:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one byte and hold it until the DUT takes it (bounded).
  task automatic put(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    din       = b;
    din_valid = 1'b1;
    while (!din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic send_kernel(input logic [1:0] layer, input logic [5:0] junk,
                             input logic [10:0] addr, input logic [7:0] off,
                             input logic [31:0] bits, input int gap, input bit pulse);
    logic [7:0] pkt[8];
    exp_t e;
    pkt[0] = {layer, junk};
    pkt[1] = {5'd0, addr[10:8]};
    pkt[2] = addr[7:0];
    pkt[3] = off;
    pkt[4] = bits[31:24];
    pkt[5] = bits[23:16];
    pkt[6] = bits[15:8];
    pkt[7] = bits[7:0];
    if (pulse) begin
      e.is_img = 1'b0; e.img = '0; e.layer = layer; e.addr = addr;
      e.off = off; e.bits = bits[31:7];
      sb.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (gap) @(negedge clk);
      put(pkt[i]);
    end
  endtask

  task automatic send_image(input logic [7:0] bytes[98]);
    exp_t e;
    e.is_img = 1'b1; e.layer = '0; e.addr = '0; e.off = '0; e.bits = '0;
    for (int j = 0; j < 98; j++)
      for (int b = 0; b < 8; b++)
        e.img[8*j + (7 - b)] = bytes[j][b];
    sb.push_back(e);
    put(8'h00);
    for (int j = 0; j < 98; j++) put(bytes[j]);
  endtask

  task automatic check_reset_outputs();
    check("rst_din_ready", din_ready, 1'b0);
    check("rst_img_valid", image_out_valid, 1'b0);
    check("rst_k_valid", kernel_out_valid, 1'b0);
    check("rst_err_addr", err_addr, 1'b0);
    check("rst_image_out", image_out, '0);
    check("rst_k_bits", kernel_bits, '0);
    check("rst_k_offset", kernel_offset, '0);
    check("rst_k_addr", kernel_addr, '0);
    check("rst_k_layer", kernel_layer, '0);
  endtask

  // Output monitor: pops the scoreboard on every result the DUT presents.
  initial begin
    bit prev_img = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready_vs_hold", din_ready, !(image_out_valid || kernel_out_valid));
        if ((image_out_valid && !prev_img) || kernel_out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            check("out_kind", image_out_valid, e.is_img);
            if (e.is_img) begin
              check("img_data", image_out, e.img);
            end else begin
              check("k_layer", kernel_layer, e.layer);
              check("k_addr", kernel_addr, e.addr);
              check("k_offset", kernel_offset, e.off);
              check("k_bits", kernel_bits, e.bits);
            end
          end
        end
      end
      prev_img = image_out_valid;
    end
  end

  initial begin
    logic [7:0] ones[98];
    logic [7:0] rnd[98];
    for (int j = 0; j < 98; j++) ones[j] = 8'hFF;

    // Reset state, then ready on the first cycle out of reset.
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", din_ready, 1'b1);

    // Image held while the consumer stalls for 5 cycles.
    image_out_ready = 1'b0;
    send_image(ones);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", image_out_valid, 1'b1);
      check("hold_ready", din_ready, 1'b0);
      check("hold_data", image_out, {784{1'b1}});
    end
    image_out_ready = 1'b1;
    @(negedge clk);
    check("idle_valid", image_out_valid, 1'b0);
    check("idle_ready", din_ready, 1'b1);

    // conv1 kernel.
    send_kernel(2'd1, 6'h00, 11'd5, 8'h12, 32'hAAAAAA80, 0, 1'b1);
    repeat (2) @(negedge clk);
    check("k1_bits_const", kernel_bits, 25'h1555555);

    // Back-to-back: random image immediately followed by a kernel.
    for (int j = 0; j < 98; j++) rnd[j] = 8'($urandom);
    send_image(rnd);
    send_kernel(2'd2, 6'h2A, 11'd1079, 8'h7E, 32'h5A3C_F0E1, 0, 1'b1);
    repeat (2) @(negedge clk);

    // Same conv1 packet with 3-cycle gaps before each byte.
    send_kernel(2'd1, 6'h00, 11'd5, 8'h12, 32'hAAAAAA80, 3, 1'b1);
    repeat (2) @(negedge clk);

    // conv2 at its limit is dropped; last good kernel is kept.
    send_kernel(2'd2, 6'h00, 11'd1080, 8'h99, 32'h1234_5678, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("err_set", err_addr, 1'b1);
    check("keep_addr", kernel_addr, 11'd5);
    check("keep_bits", kernel_bits, 25'h1555555);
    send_kernel(2'd3, 6'h00, 11'd9, 8'h33, 32'hFF00FF00, 0, 1'b1);
    repeat (2) @(negedge clk);
    check("err_sticky", err_addr, 1'b1);
    check("fc_bits_const", kernel_bits, 25'h1FE01FE);

    // Reset after 50 image bytes, then a fresh image.
    put(8'h00);
    for (int j = 0; j < 50; j++) put(8'hFF);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst2", din_ready, 1'b1);
    for (int j = 0; j < 98; j++) rnd[j] = 8'($urandom);
    send_image(rnd);
    repeat (4) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 SHALL have parameter bW, default 8, giving the kernel offset width.
REQ-002 SHALL have parameter IMG_BYTES, default 98, giving the number of image payload bytes (784 pixels / 8).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port din  input  8  inbound byte stream.
REQ-006 SHALL have port din_valid  input  1  din holds a byte.
REQ-007 SHALL have port din_ready  output  1  loader accepts din this cycle.
REQ-008 SHALL have port image_out  output  784  image, pixel p=28*row+col at bit p.
REQ-009 SHALL have port image_out_valid  output  1  image_out complete and held.
REQ-010 SHALL have port image_out_ready  input  1  consumer accepts the image.
REQ-011 SHALL have port kernel_out_valid  output  1  one-cycle kernel write strobe.
REQ-012 SHALL have port kernel_bits  output  25  kernel bit k = tap row k/5, column k%5.
REQ-013 SHALL have port kernel_offset  output  bW  kernel offset.
REQ-014 SHALL have port kernel_addr  output  11  kernel index within its layer.
REQ-015 SHALL have port kernel_layer  output  2  1=conv1, 2=conv2, 3=fc.
REQ-016 SHALL have port err_addr  output  1  sticky flag: an out-of-range kernel packet was dropped.

Function
REQ-017 SHALL accept a byte only when din_valid and din_ready are both high (a transfer).
REQ-018 SHALL decode the first byte of each packet as a header: bits[7:6] are the type (0=image, 1..3=kernel layer); bits[5:0] are ignored.
REQ-019 SHALL expect an image packet to be the header followed by IMG_BYTES bytes, byte j bit 7 down to bit 0 mapping to pixels 8j..8j+7.
REQ-020 SHALL expect a kernel packet to be the header, addr[10:8] in bits[2:0] of the next byte, addr[7:0], offset, then 4 bits bytes; kernel bits 24..0 come from the first 25 payload bits MSB-first, and the last 7 bits are ignored.
REQ-021 SHALL implement FSM states IDLE -> HDR decode -> {IMG, K_AH, K_AL, K_OFF, K_BITS} -> {IMG_HOLD, K_EMIT} -> IDLE, advancing one state per transfer inside a packet.
REQ-022 SHALL drive din_ready high in every state except IMG_HOLD and K_EMIT, where it is low.
REQ-023 SHALL, in IMG, count bytes 0..IMG_BYTES-1 and enter IMG_HOLD on the transfer of the last byte.
REQ-024 SHALL, in IMG_HOLD, keep image_out_valid high and image_out stable until image_out_ready is high, then return to IDLE on the next cycle.
REQ-025 SHALL, on the 4th bits byte, enter K_EMIT; K_EMIT SHALL last exactly one cycle with kernel_out_valid high, then return to IDLE.
REQ-026 SHALL keep kernel_bits, kernel_offset, kernel_addr and kernel_layer stable from K_EMIT until the next K_EMIT.
REQ-027 SHALL use these address limits: layer1 addr<90, layer2 addr<1080, fc addr<10.
REQ-028 SHALL, for an out-of-limit kernel packet, consume it fully, suppress the kernel_out_valid pulse, and set err_addr.
REQ-029 SHALL hold kernel_out_valid low, with kernel_bits unchanged, whenever din_valid is low mid-packet; gaps of any length SHALL be tolerated.
REQ-030 SHALL make image_out visible only from IMG_HOLD; partially assembled pixels SHALL NOT appear on image_out before IMG_HOLD.
REQ-031 SHALL have a latency of 1 cycle from the last-byte transfer to image_out_valid or kernel_out_valid.

Reset
REQ-032 SHALL, while rst is high at a clock edge, enter IDLE, discard any partial packet and clear the byte counter.
REQ-033 SHALL, during reset, drive din_ready=0, image_out_valid=0, kernel_out_valid=0, err_addr=0, image_out=0, kernel_bits=0, kernel_offset=0, kernel_addr=0 and kernel_layer=0.
REQ-034 SHALL drive din_ready=1 on the first cycle after rst deasserts.

Structure
REQ-035 SHALL take the packet-type enum, IMG_BYTES, KBITS_BYTES=4 and the three address limits from shared package bnn_pkg.
REQ-036 SHALL be a single module with no sub-modules; image assembly SHALL be an in-place 784-bit shift register.

Verification
REQ-037 SHALL verify an image load: header 0x00 plus 98 bytes of 0xFF, then image_out_ready held low for 5 cycles -> image_out all ones, image_out_valid high for those 5 cycles, din_ready=0, IDLE one cycle after ready.
REQ-038 SHALL verify a conv1 kernel load: bytes 0x40,0x00,0x05,0x12,0xAA,0xAA,0xAA,0x80 -> one cycle later kernel_out_valid pulses once with layer=1, addr=5, offset=0x12, bits=25'h1555555.
REQ-039 SHALL verify range checking: a conv2 kernel with addr=1080 -> no kernel_out_valid pulse and err_addr=1; a following valid fc packet with addr=9 -> a pulse, with err_addr still 1.
REQ-040 SHALL verify tolerance of input gaps: the REQ-038 packet with din_valid dropped for 3 cycles between each byte -> an identical single pulse.
REQ-041 SHALL verify reset mid-packet: rst asserted after image byte 50, then a fresh image packet -> no stale pixels and a correct image.
REQ-042 SHALL verify back-to-back packets: a kernel packet immediately after image acceptance -> no lost bytes, with din_ready low only during IMG_HOLD and K_EMIT.
